// File: rtl/ula_74181_if.sv
// Operand/result bundle for one 74181-compatible ALU slice.
// The master drives operands and function select; the slave returns registered results.
interface ula_74181_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       a_eq_b;
    logic       c_out;

    modport master (
        output a, b, s, m, c_in,
        input  f, a_eq_b, c_out
    );

    modport slave (
        input  a, b, s, m, c_in,
        output f, a_eq_b, c_out
    );
endinterface

// File: rtl/ula_74181.sv
// 4-bit ALU slice, function-compatible with the 74181 (active-high data), registered outputs.
// Arithmetic mode forms {c_out,f} = X + Y + c_in from per-function operand pairs.
module ula_74181 (
    input  logic         clk,
    input  logic         rst,
    ula_74181_if.slave   bus
);

    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [3:0] w_logic;
    logic [4:0] w_sum;
    logic [3:0] w_f_next;
    logic       w_c_next;

    logic [3:0] r_f;
    logic       r_c_out;
    logic       r_a_eq_b;

    always_comb begin
        w_logic = 4'b0000;
        case (bus.s)
            4'h0: w_logic = ~bus.a;
            4'h1: w_logic = ~(bus.a | bus.b);
            4'h2: w_logic = ~bus.a & bus.b;
            4'h3: w_logic = 4'b0000;
            4'h4: w_logic = ~(bus.a & bus.b);
            4'h5: w_logic = ~bus.b;
            4'h6: w_logic = bus.a ^ bus.b;
            4'h7: w_logic = bus.a & ~bus.b;
            4'h8: w_logic = ~bus.a | bus.b;
            4'h9: w_logic = ~(bus.a ^ bus.b);
            4'hA: w_logic = bus.b;
            4'hB: w_logic = bus.a & bus.b;
            4'hC: w_logic = 4'b1111;
            4'hD: w_logic = bus.a | ~bus.b;
            4'hE: w_logic = bus.a | bus.b;
            4'hF: w_logic = bus.a;
        endcase
    end

    // Operand pair for the adder; subtract-style functions use ~B or all-ones as Y.
    always_comb begin
        w_x = 4'b0000;
        w_y = 4'b0000;
        case (bus.s)
            4'h0: begin w_x = bus.a;            w_y = 4'b0000;          end
            4'h1: begin w_x = bus.a | bus.b;    w_y = 4'b0000;          end
            4'h2: begin w_x = bus.a | ~bus.b;   w_y = 4'b0000;          end
            4'h3: begin w_x = 4'b0000;          w_y = 4'b1111;          end
            4'h4: begin w_x = bus.a;            w_y = bus.a & ~bus.b;   end
            4'h5: begin w_x = bus.a | bus.b;    w_y = bus.a & ~bus.b;   end
            4'h6: begin w_x = bus.a;            w_y = ~bus.b;           end
            4'h7: begin w_x = bus.a & ~bus.b;   w_y = 4'b1111;          end
            4'h8: begin w_x = bus.a;            w_y = bus.a & bus.b;    end
            4'h9: begin w_x = bus.a;            w_y = bus.b;            end
            4'hA: begin w_x = bus.a | ~bus.b;   w_y = bus.a & bus.b;    end
            4'hB: begin w_x = bus.a & bus.b;    w_y = 4'b1111;          end
            4'hC: begin w_x = bus.a;            w_y = bus.a;            end
            4'hD: begin w_x = bus.a | bus.b;    w_y = bus.a;            end
            4'hE: begin w_x = bus.a | ~bus.b;   w_y = bus.a;            end
            4'hF: begin w_x = bus.a;            w_y = 4'b1111;          end
        endcase
    end

    assign w_sum    = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, bus.c_in};
    assign w_f_next = bus.m ? w_logic : w_sum[3:0];
    assign w_c_next = ~bus.m & w_sum[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f      <= 4'b0000;
            r_c_out  <= 1'b0;
            r_a_eq_b <= 1'b0;
        end else begin
            r_f      <= w_f_next;
            r_c_out  <= w_c_next;
            r_a_eq_b <= (w_f_next == 4'b1111);
        end
    end

    assign bus.f      = r_f;
    assign bus.c_out  = r_c_out;
    assign bus.a_eq_b = r_a_eq_b;

endmodule

// File: tb/tb_ula_74181.sv
// Bench for ula_74181: directed hand-computed vectors, then a full sweep
// of m/s/a/b/c_in against a per-bit truth-table reference model.
module tb_ula_74181;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ula_74181_if bus ();

    ula_74181 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit truth tables indexed by {a_bit, b_bit}: logic result, adder X, adder Y.
    logic [3:0] tt_logic [16];
    logic [3:0] tt_x     [16];
    logic [3:0] tt_y     [16];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] apply_tt(input logic [3:0] tt, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic drive(input logic m, input logic [3:0] s, input logic [3:0] a,
                         input logic [3:0] b, input logic c_in);
        bus.m    = m;
        bus.s    = s;
        bus.a    = a;
        bus.b    = b;
        bus.c_in = c_in;
    endtask

    task automatic run_vec(input string tag, input logic m, input logic [3:0] s,
                           input logic [3:0] a, input logic [3:0] b, input logic c_in,
                           input logic [3:0] exp_f, input logic exp_c, input logic exp_eq);
        drive(m, s, a, b, c_in);
        @(posedge clk);
        #1;
        check_val({tag, ".f"},      {4'h0, bus.f},      {4'h0, exp_f});
        check_val({tag, ".c_out"},  {7'h0, bus.c_out},  {7'h0, exp_c});
        check_val({tag, ".a_eq_b"}, {7'h0, bus.a_eq_b}, {7'h0, exp_eq});
    endtask

    initial begin
        logic [3:0] ef;
        logic [4:0] es;
        logic       ec;

        n_tests = 0;
        n_fail  = 0;
        tt_logic = '{4'b0011, 4'b0001, 4'b0010, 4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100,
                     4'b1011, 4'b1001, 4'b1010, 4'b1000, 4'b1111, 4'b1101, 4'b1110, 4'b1100};
        tt_x     = '{4'b1100, 4'b1110, 4'b1101, 4'b0000, 4'b1100, 4'b1110, 4'b1100, 4'b0100,
                     4'b1100, 4'b1100, 4'b1101, 4'b1000, 4'b1100, 4'b1110, 4'b1101, 4'b1100};
        tt_y     = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 4'b0100, 4'b0101, 4'b1111,
                     4'b1000, 4'b1010, 4'b1000, 4'b1111, 4'b1100, 4'b1100, 4'b1100, 4'b1111};

        // Reset with inputs that would otherwise produce 1111 and a carry-free all-ones flag
        rst = 1'b1;
        drive(1'b1, 4'hC, 4'h5, 4'h3, 1'b1);
        @(posedge clk);
        #1;
        check_val("rst.f",      {4'h0, bus.f},      8'h00);
        check_val("rst.c_out",  {7'h0, bus.c_out},  8'h00);
        check_val("rst.a_eq_b", {7'h0, bus.a_eq_b}, 8'h00);
        drive(1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        check_val("rst_carry.c_out", {7'h0, bus.c_out}, 8'h00);
        rst = 1'b0;

        run_vec("add",       1'b0, 4'h9, 4'h7, 4'h5, 1'b0, 4'hC, 1'b0, 1'b0);
        run_vec("add_wrap",  1'b0, 4'h9, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        run_vec("cmp_eq",    1'b0, 4'h6, 4'hA, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1);
        run_vec("sub",       1'b0, 4'h6, 4'hA, 4'h3, 1'b1, 4'h7, 1'b1, 1'b0);
        run_vec("lg_xor",    1'b1, 4'h6, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0);
        run_vec("lg_and",    1'b1, 4'hB, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0);
        run_vec("lg_or",     1'b1, 4'hE, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0);
        run_vec("lg_ones",   1'b1, 4'hC, 4'hC, 4'hA, 1'b1, 4'hF, 1'b0, 1'b1);
        run_vec("lg_zero",   1'b1, 4'h3, 4'hC, 4'hA, 1'b1, 4'h0, 1'b0, 1'b0);
        run_vec("dec_zero",  1'b0, 4'hF, 4'h0, 4'h5, 1'b0, 4'hF, 1'b0, 1'b1);
        run_vec("dec_cin",   1'b0, 4'hF, 4'h0, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0);
        run_vec("minus1",    1'b0, 4'h3, 4'h5, 4'h9, 1'b0, 4'hF, 1'b0, 1'b1);
        run_vec("double",    1'b0, 4'hC, 4'h9, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0);
        run_vec("cmp_ne",    1'b0, 4'h6, 4'h4, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0);

        // Full sweep, one vector per cycle, each checked right after its capturing edge
        for (int mi = 0; mi < 2; mi++)
            for (int si = 0; si < 16; si++)
                for (int ai = 0; ai < 16; ai++)
                    for (int bi = 0; bi < 16; bi++)
                        for (int ci = 0; ci < 2; ci++) begin
                            drive(mi[0], si[3:0], ai[3:0], bi[3:0], ci[0]);
                            if (mi == 1) begin
                                ef = apply_tt(tt_logic[si], ai[3:0], bi[3:0]);
                                ec = 1'b0;
                            end else begin
                                es = {1'b0, apply_tt(tt_x[si], ai[3:0], bi[3:0])}
                                   + {1'b0, apply_tt(tt_y[si], ai[3:0], bi[3:0])}
                                   + {4'h0, ci[0]};
                                ef = es[3:0];
                                ec = es[4];
                            end
                            @(posedge clk);
                            #1;
                            check_val($sformatf("sweep m%0d s%h a%h b%h c%0d", mi, si, ai, bi, ci),
                                      {2'b00, bus.a_eq_b, bus.c_out, bus.f},
                                      {2'b00, (ef == 4'hF), ec, ef});
                        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
